// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer: channel state
// encoding and counter width sizing.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } deb_state_t;

    // Bits needed to hold the values 0..max_val inclusive, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounced button: accepts a level change only after STABLE_TICKS agreeing
// strobes and emits registered press/release/hold pulses.
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int HOLD_TICKS   = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_strobe,
    input  logic i_samp,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int CW = cnt_width(STABLE_TICKS);
    localparam int HW = cnt_width(HOLD_TICKS);
    localparam logic [CW-1:0] C_STABLE = CW'(STABLE_TICKS);
    localparam logic [HW-1:0] C_HOLD   = HW'(HOLD_TICKS);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    deb_state_t    r_state;
    deb_state_t    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_inc;
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt_next;
    logic [HW-1:0] w_hcnt_inc;
    logic          r_press;
    logic          r_release;
    logic          r_hold;
    logic          w_press_next;
    logic          w_release_next;
    logic          w_hold_next;

    assign w_cnt_inc  = r_cnt + C_ONE;
    assign w_hcnt_inc = r_hcnt + HW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_hcnt    <= w_hcnt_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_hold    <= w_hold_next;
        end
    end

    // Pulse flags default low, so every pulse lasts exactly one clock.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_hcnt_next    = r_hcnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_hold_next    = 1'b0;
        if (i_strobe) begin
            unique case (r_state)
                ST_RELEASED: begin
                    if (i_samp) begin
                        if (STABLE_TICKS == 1) begin
                            w_state_next = ST_PRESSED;
                            w_press_next = 1'b1;
                            w_hcnt_next  = '0;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = ST_PRESS_CHK;
                            w_cnt_next   = C_ONE;
                        end
                    end
                end
                ST_PRESS_CHK: begin
                    if (i_samp) begin
                        if (w_cnt_inc >= C_STABLE) begin
                            w_state_next = ST_PRESSED;
                            w_press_next = 1'b1;
                            w_hcnt_next  = '0;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else begin
                        w_state_next = ST_RELEASED;
                        w_cnt_next   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (i_samp) begin
                        if (r_hcnt < C_HOLD) begin
                            w_hcnt_next = w_hcnt_inc;
                            w_hold_next = (w_hcnt_inc == C_HOLD);
                        end
                    end else if (STABLE_TICKS == 1) begin
                        w_state_next   = ST_RELEASED;
                        w_release_next = 1'b1;
                        w_cnt_next     = '0;
                    end else begin
                        w_state_next = ST_RELEASE_CHK;
                        w_cnt_next   = C_ONE;
                    end
                end
                ST_RELEASE_CHK: begin
                    // A bounce back to pressed keeps hcnt, so a saturated hold never refires.
                    if (!i_samp) begin
                        if (w_cnt_inc >= C_STABLE) begin
                            w_state_next   = ST_RELEASED;
                            w_release_next = 1'b1;
                            w_cnt_next     = '0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else begin
                        w_state_next = ST_PRESSED;
                        w_cnt_next   = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        o_level   = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_CHK);
        o_press   = r_press;
        o_release = r_release;
        o_hold    = r_hold;
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN raw buttons in the clkIn domain, using the rising edge of the
// synchronized tickIn as the sample strobe.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int STABLE_TICKS   = 4,
    parameter int HOLD_TICKS     = 64,
    parameter bit ACTIVE_LOW_BTN = 1'b0
) (
    input  logic               clkIn,
    input  logic               reset,
    input  logic               tickIn,
    input  logic [NUM_BTN-1:0] btnIn,
    output logic [NUM_BTN-1:0] btnLevel,
    output logic [NUM_BTN-1:0] btnPress,
    output logic [NUM_BTN-1:0] btnRelease,
    output logic [NUM_BTN-1:0] btnHold
);

    // Raw pin level that means "not pressed"; the button synchronizers rest here.
    localparam logic [NUM_BTN-1:0] BTN_IDLE = {NUM_BTN{ACTIVE_LOW_BTN}};

    logic [NUM_BTN-1:0] r_btn_meta;
    logic [NUM_BTN-1:0] r_btn_sync;
    logic [NUM_BTN-1:0] w_samp;
    logic               r_tick_meta;
    logic               r_tick_sync;
    logic               r_tick_prev;
    logic               w_strobe;

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            r_btn_meta  <= BTN_IDLE;
            r_btn_sync  <= BTN_IDLE;
            r_tick_meta <= 1'b0;
            r_tick_sync <= 1'b0;
            r_tick_prev <= 1'b0;
        end else begin
            r_btn_meta  <= btnIn;
            r_btn_sync  <= r_btn_meta;
            r_tick_meta <= tickIn;
            r_tick_sync <= r_tick_meta;
            r_tick_prev <= r_tick_sync;
        end
    end

    assign w_strobe = r_tick_sync & ~r_tick_prev;
    assign w_samp   = r_btn_sync ^ BTN_IDLE;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            button_debouncer_channel #(
                .STABLE_TICKS (STABLE_TICKS),
                .HOLD_TICKS   (HOLD_TICKS)
            ) u_ch (
                .i_clk     (clkIn),
                .i_rst_n   (reset),
                .i_strobe  (w_strobe),
                .i_samp    (w_samp[gi]),
                .o_level   (btnLevel[gi]),
                .o_press   (btnPress[gi]),
                .o_release (btnRelease[gi]),
                .o_hold    (btnHold[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Directed plus randomized bench for button_debouncer; an active-high and an
// active-low instance are both checked every cycle against one behavioural model.
module tb_button_debouncer;

    localparam int NB = 4;
    localparam int ST = 4;
    localparam int HT = 64;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick  = 1'b0;
    logic [NB-1:0] btn   = '0;
    logic [NB-1:0] btn_n;
    logic [NB-1:0] lvl_a, prs_a, rel_a, hld_a;
    logic [NB-1:0] lvl_b, prs_b, rel_b, hld_b;

    assign btn_n = ~btn;

    always #5 clk = ~clk;

    button_debouncer #(.NUM_BTN(NB), .STABLE_TICKS(ST), .HOLD_TICKS(HT), .ACTIVE_LOW_BTN(1'b0)) dut (
        .clkIn(clk), .reset(rst_n), .tickIn(tick), .btnIn(btn),
        .btnLevel(lvl_a), .btnPress(prs_a), .btnRelease(rel_a), .btnHold(hld_a)
    );

    button_debouncer #(.NUM_BTN(NB), .STABLE_TICKS(ST), .HOLD_TICKS(HT), .ACTIVE_LOW_BTN(1'b1)) dut_n (
        .clkIn(clk), .reset(rst_n), .tickIn(tick), .btnIn(btn_n),
        .btnLevel(lvl_b), .btnPress(prs_b), .btnRelease(rel_b), .btnHold(hld_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Behavioural model: accepted level, run of disagreeing strobes, hold strobe count.
    logic [NB-1:0] m_lvl, m_press, m_rel, m_hold;
    int            m_run  [NB];
    int            m_hcnt [NB];
    logic [NB-1:0] hb1, hb2;
    logic          ht1, ht2, ht3;

    int pc_press [NB];
    int pc_rel   [NB];
    int pc_hold  [NB];
    int all_four;

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        m_lvl = '0; m_press = '0; m_rel = '0; m_hold = '0;
        for (int c = 0; c < NB; c++) begin
            m_run[c]  = 0;
            m_hcnt[c] = 0;
        end
        hb1 = '0; hb2 = '0;
        ht1 = 1'b0; ht2 = 1'b0; ht3 = 1'b0;
    endtask

    // Inputs reach the decision logic two clocks after they are sampled.
    task automatic model_edge();
        logic          strobe;
        logic [NB-1:0] samp;
        strobe  = ht2 & ~ht3;
        samp    = hb2;
        m_press = '0; m_rel = '0; m_hold = '0;
        if (strobe) begin
            for (int c = 0; c < NB; c++) begin
                if (samp[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= ST) begin
                        m_lvl[c] = samp[c];
                        m_run[c] = 0;
                        if (samp[c]) begin
                            m_press[c] = 1'b1;
                            m_hcnt[c]  = 0;
                        end else begin
                            m_rel[c] = 1'b1;
                        end
                    end
                end else begin
                    if (m_lvl[c] && m_run[c] == 0 && m_hcnt[c] < HT) begin
                        m_hcnt[c]++;
                        if (m_hcnt[c] == HT) m_hold[c] = 1'b1;
                    end
                    m_run[c] = 0;
                end
            end
        end
        ht3 = ht2; ht2 = ht1; ht1 = tick;
        hb2 = hb1; hb1 = btn;
    endtask

    task automatic check_outputs();
        chk("level_ah",   lvl_a, m_lvl);
        chk("press_ah",   prs_a, m_press);
        chk("release_ah", rel_a, m_rel);
        chk("hold_ah",    hld_a, m_hold);
        chk("level_al",   lvl_b, m_lvl);
        chk("press_al",   prs_b, m_press);
        chk("release_al", rel_b, m_rel);
        chk("hold_al",    hld_b, m_hold);
    endtask

    task automatic clr_counts();
        for (int c = 0; c < NB; c++) begin
            pc_press[c] = 0; pc_rel[c] = 0; pc_hold[c] = 0;
        end
        all_four = 0;
    endtask

    task automatic step();
        tick = ((cyc % 12) < 6);
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge();
        #1;
        check_outputs();
        for (int c = 0; c < NB; c++) begin
            pc_press[c] += int'(prs_a[c]);
            pc_rel[c]   += int'(rel_a[c]);
            pc_hold[c]  += int'(hld_a[c]);
        end
        if (prs_a == 4'b1111) all_four++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        btn = '0;
        run(cycles);
        rst_n = 1'b1;
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int c = 0; c < NB; c++) s += pc_press[c] + pc_rel[c] + pc_hold[c];
        return s;
    endfunction

    initial begin
        int waited;
        int rate [NB];

        model_reset();
        clr_counts();
        do_reset(4);
        run(30);
        chk_int("idle_no_pulses", total_pulses(), 0);
        $display("reset/idle: level=%b pulses=%0d", lvl_a, total_pulses());

        // Clean press on button 0.
        clr_counts();
        btn[0] = 1'b1;
        run(100);
        chk_int("t1_press_count", pc_press[0], 1);
        chk("t1_level", lvl_a & 4'b0001, 4'b0001);
        $display("clean press: presses=%0d level=%b", pc_press[0], lvl_a);

        // Bouncing button 1, then a steady press.
        clr_counts();
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) btn[1] = ~btn[1];
            step();
        end
        chk_int("t2_bounce_press", pc_press[1], 0);
        btn[1] = 1'b1;
        run(100);
        chk_int("t2_settled_press", pc_press[1], 1);
        $display("bounce: presses=%0d level=%b", pc_press[1], lvl_a);

        // Long hold on button 2, then release.
        clr_counts();
        btn[2] = 1'b1;
        run(80 * 12);
        btn[2] = 1'b0;
        run(100);
        chk_int("t3_press", pc_press[2], 1);
        chk_int("t3_hold", pc_hold[2], 1);
        chk_int("t3_release", pc_rel[2], 1);
        $display("long hold: press=%0d hold=%0d release=%0d", pc_press[2], pc_hold[2], pc_rel[2]);

        // Short release glitch on a held button 0.
        clr_counts();
        btn[0] = 1'b0;
        run(24);
        btn[0] = 1'b1;
        run(100);
        chk_int("t4_no_release", pc_rel[0], 0);
        chk_int("t4_no_hold", pc_hold[0], 0);
        chk("t4_level", lvl_a & 4'b0001, 4'b0001);
        $display("release glitch: release=%0d hold=%0d level=%b", pc_rel[0], pc_hold[0], lvl_a);

        // All buttons pressed in the same cycle.
        btn = '0;
        run(150);
        clr_counts();
        btn = 4'b1111;
        run(100);
        chk_int("t5_simultaneous", all_four, 1);
        chk_int("t5_press_total", pc_press[0] + pc_press[1] + pc_press[2] + pc_press[3], 4);
        $display("simultaneous: all-four cycles=%0d", all_four);

        // Reset aborting a press check, then a held press.
        btn = '0;
        run(150);
        btn[3] = 1'b1;
        waited = 0;
        while (waited < 200 && m_run[3] != 2) begin
            step();
            waited++;
        end
        chk_int("t6_reach_check", int'(m_run[3] == 2), 1);
        do_reset(3);
        clr_counts();
        run(100);
        chk_int("t6a_no_pulses", total_pulses(), 0);
        btn[3] = 1'b1;
        waited = 0;
        while (waited < 200 && !m_lvl[3]) begin
            step();
            waited++;
        end
        chk("t6_pressed", lvl_a & 4'b1000, 4'b1000);
        run(50);
        do_reset(3);
        clr_counts();
        run(100);
        chk_int("t6b_no_pulses", total_pulses(), 0);
        $display("reset mid-op: pulses after release=%0d level=%b", total_pulses(), lvl_a);

        // Randomized segments mixing steady, slow and bouncy channels.
        for (int seg = 0; seg < 10; seg++) begin
            for (int c = 0; c < NB; c++) begin
                case ($urandom_range(3))
                    0:       rate[c] = 0;
                    1:       rate[c] = 4;
                    2:       rate[c] = 40;
                    default: rate[c] = 150;
                endcase
            end
            clr_counts();
            for (int i = 0; i < 300; i++) begin
                for (int c = 0; c < NB; c++)
                    if (rate[c] != 0 && $urandom_range(rate[c] - 1) == 0) btn[c] = ~btn[c];
                step();
            end
            $display("random seg %0d: presses=%0d/%0d/%0d/%0d level=%b", seg,
                     pc_press[0], pc_press[1], pc_press[2], pc_press[3], lvl_a);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
